fetch_stage: RTL and testbench

//  Instruction fetch stage plus IF/ID pipeline register, directly upstream of the

---
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: fetch stage drives req/addr, memory returns ack/rdata.
interface fetch_stage_if #(
    parameter int AW = 32
);
    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [31:0]   rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Purpose: PC + instruction fetch over req/ack port, latched into the IF/ID register feeding Control.
// Latency: ack at cycle N -> op/fn valid at N+1; redirect at N -> target requested at N+1 (or after pending ack).
// Backpressure: stall holds IF/ID and PC; a word acked under stall parks in a one-entry skid buffer (req=0 there).
module fetch_stage #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rstn,
    fetch_stage_if.master    imem,
    input  logic             stall,
    input  logic             redirect,
    input  logic [AW-1:0]    redirect_pc,
    output logic             ifid_valid,
    output logic [31:0]      ifid_instr,
    output logic [AW-1:0]    ifid_pc4,
    output logic [5:0]       op,
    output logic [5:0]       fn
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_BUF   = 1'b1;

    logic [0:0]    state;
    logic          run;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_next;
    logic          kill;
    logic          buf_valid;
    logic [31:0]   buf_instr;
    logic [AW-1:0] buf_pc4;
    logic [31:0]   instr_q;

    logic          fire;
    logic          pending;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] redir_tgt;
    logic          unused_redirect_lsb;

    // run keeps req low for the first cycle after reset so a stale ack is ignored
    assign imem.req  = run && (state == S_FETCH);
    assign imem.addr = pc;

    assign fire      = imem.req && imem.ack;
    assign pending   = imem.req && !imem.ack;
    assign pc_inc    = pc + AW'(4);
    assign redir_tgt = {redirect_pc[AW-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // An empty slot must decode as op=0/fn=0 downstream
    assign ifid_instr = ifid_valid ? instr_q : 32'h0;
    assign op         = ifid_instr[31:26];
    assign fn         = ifid_instr[5:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_FETCH;
            run        <= 1'b0;
            pc         <= RESET_PC;
            pc_next    <= '0;
            kill       <= 1'b0;
            buf_valid  <= 1'b0;
            buf_instr  <= '0;
            buf_pc4    <= '0;
            ifid_valid <= 1'b0;
            instr_q    <= '0;
            ifid_pc4   <= '0;
        end else begin
            run <= 1'b1;
            if (redirect) begin
                ifid_valid <= 1'b0;
                buf_valid  <= 1'b0;
                state      <= S_FETCH;
                if (pending) begin
                    // address must stay put until the in-flight read is acked
                    pc_next <= redir_tgt;
                    kill    <= 1'b1;
                end else begin
                    pc   <= redir_tgt;
                    kill <= 1'b0;
                end
            end else if (state == S_BUF) begin
                if (!stall) begin
                    ifid_valid <= buf_valid;
                    instr_q    <= buf_instr;
                    ifid_pc4   <= buf_pc4;
                    buf_valid  <= 1'b0;
                    state      <= S_FETCH;
                end
            end else if (fire && kill) begin
                kill <= 1'b0;
                pc   <= pc_next;
                if (!stall) begin
                    ifid_valid <= 1'b0;
                end
            end else if (fire && stall && ifid_valid) begin
                buf_instr <= imem.rdata;
                buf_pc4   <= pc_inc;
                buf_valid <= 1'b1;
                pc        <= pc_inc;
                state     <= S_BUF;
            end else if (fire) begin
                instr_q    <= imem.rdata;
                ifid_valid <= 1'b1;
                ifid_pc4   <= pc_inc;
                pc         <= pc_inc;
            end else if (!stall) begin
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: combinational memory model, hand-computed IF/ID expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ack = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic [5:0]  op;
    logic [5:0]  fn;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage_if #(.AW(32)) bus ();

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0085_1020;
        else if (a == 32'h4) return 32'h20A5_0004;
        else                 return {16'hA000, a[15:0]};
    endfunction

    assign bus.ack   = ack;
    assign bus.rdata = word_at(bus.addr);

    fetch_stage #(.AW(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .op          (op),
        .fn          (fn)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_req",   64'(bus.req),    64'h0);
        chk("rst_valid", 64'(ifid_valid), 64'h0);
        chk("rst_instr", 64'(ifid_instr), 64'h0);
        chk("rst_pc4",   64'(ifid_pc4),   64'h0);
        chk("rst_opfn",  64'({op, fn}),   64'h0);

        // 1: straight-line fetch, ack every cycle
        rstn = 1'b1;
        ack  = 1'b1;
        tick();
        chk("t1_req",    64'(bus.req),    64'h1);
        chk("t1_addr0",  64'(bus.addr),   64'h0);
        chk("t1_empty",  64'(ifid_valid), 64'h0);
        tick();
        chk("t1_op0",    64'(op),         64'h00);
        chk("t1_fn0",    64'(fn),         64'h20);
        chk("t1_pc4_0",  64'(ifid_pc4),   64'h4);
        chk("t1_addr4",  64'(bus.addr),   64'h4);
        tick();
        chk("t1_op1",    64'(op),         64'h08);
        chk("t1_fn1",    64'(fn),         64'h04);
        chk("t1_addr8",  64'(bus.addr),   64'h8);

        // 2: stall 3 cycles with ack held -> word at 8 buffered
        stall = 1'b1;
        tick();
        chk("t2_req_buf", 64'(bus.req),    64'h0);
        chk("t2_hold",    64'(ifid_instr), 64'h20A5_0004);
        chk("t2_hold_p4", 64'(ifid_pc4),   64'h8);
        tick();
        tick();
        chk("t2_req_buf3", 64'(bus.req),    64'h0);
        chk("t2_hold3",    64'(ifid_instr), 64'h20A5_0004);
        stall = 1'b0;
        tick();
        chk("t2_unbuf",   64'(ifid_instr), 64'hA000_0008);
        chk("t2_unbuf_p4",64'(ifid_pc4),   64'hC);
        chk("t2_addr12",  64'(bus.addr),   64'hC);
        chk("t2_req_on",  64'(bus.req),    64'h1);
        tick();
        chk("t2_next",    64'(ifid_instr), 64'hA000_000C);
        chk("t2_addr16",  64'(bus.addr),   64'h10);

        // 3: redirect with ack in the same cycle
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("t3_flush",   64'(ifid_valid), 64'h0);
        chk("t3_opfn",    64'({op, fn}),   64'h0);
        chk("t3_instr",   64'(ifid_instr), 64'h0);
        chk("t3_addr",    64'(bus.addr),   64'h40);
        tick();
        chk("t3_target",  64'(ifid_instr), 64'hA000_0040);
        chk("t3_pc4",     64'(ifid_pc4),   64'h44);

        // 4: redirect to 0x80 while the read at 0x10 is outstanding
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        tick();
        redirect = 1'b0;
        ack      = 1'b0;
        chk("t4_addr10",  64'(bus.addr),   64'h10);
        tick();
        chk("t4_bubble",  64'(ifid_valid), 64'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h82;
        tick();
        redirect = 1'b0;
        chk("t4_hold_a",  64'(bus.addr),   64'h10);
        chk("t4_req",     64'(bus.req),    64'h1);
        tick();
        chk("t4_hold_b",  64'(bus.addr),   64'h10);
        ack = 1'b1;
        tick();
        chk("t4_dropped", 64'(ifid_valid), 64'h0);
        chk("t4_addr80",  64'(bus.addr),   64'h80);
        tick();
        chk("t4_target",  64'(ifid_instr), 64'hA000_0080);
        chk("t4_pc4",     64'(ifid_pc4),   64'h84);

        // 5: PC wrap at top of address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("t5_addr_top", 64'(bus.addr),   64'hFFFF_FFFC);
        tick();
        chk("t5_instr",    64'(ifid_instr), 64'hA000_FFFC);
        chk("t5_pc4_wrap", 64'(ifid_pc4),   64'h0);
        chk("t5_addr_wrap",64'(bus.addr),   64'h0);

        // 6: reset mid-request with a late ack during reset
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        ack      = 1'b0;
        tick();
        chk("t6_pending", 64'(bus.addr),   64'h20);
        rstn = 1'b0;
        #1;
        chk("t6_rst_req", 64'(bus.req),    64'h0);
        chk("t6_rst_vld", 64'(ifid_valid), 64'h0);
        ack = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("t6_addr",    64'(bus.addr),   64'h0);
        chk("t6_req",     64'(bus.req),    64'h1);
        chk("t6_valid",   64'(ifid_valid), 64'h0);
        chk("t6_instr",   64'(ifid_instr), 64'h0);
        ack = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
